// File: rtl/uart_receiving_pkg.sv
// Shared types for the UART receiver: receive state encoding.
package uart_receiving_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with first-word fall-through head; pointers carry one extra wrap bit.
module uart_rx_fifo #(
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(depth):0]   count
);
    localparam int AW = $clog2(depth);

    logic [7:0]  mem_reg [depth];
    logic [AW:0] wptr_reg;
    logic [AW:0] rptr_reg;
    logic        do_pop;
    logic        do_push;

    assign count   = wptr_reg - rptr_reg;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(depth));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_reg[rptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            for (int i = 0; i < depth; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wptr_reg[AW-1:0]] <= push_data;
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (do_pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_receiving.sv
// 8N1 UART receiver: two-flop synchroniser, oversampling receive FSM and byte FIFO.
module uart_receiving
    import uart_receiving_pkg::*;
#(
    parameter int clk_freq   = 1_000_000,
    parameter int baud_rate  = 9600,
    parameter int fifo_depth = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic                          framing_error,
    output logic                          overrun
);
    localparam int BIT  = clk_freq / baud_rate;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    generate
        if (BIT < 4) begin : g_bit_check
            $error("uart_receiving: clk_freq/baud_rate must be at least 4");
        end
        if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_depth_check
            $error("uart_receiving: fifo_depth must be a power of two, at least 2");
        end
    endgenerate

    rx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    shreg_reg, shreg_next;
    logic          rx_meta_reg, rx_s_reg;
    logic          framing_error_reg, overrun_reg;
    logic          push_req, stop_bad, pop, fifo_empty, fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shreg_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shreg_reg <= shreg_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shreg_next = shreg_reg;
        case (state_reg)
            S_IDLE: begin
                if (!rx_s_reg) begin
                    cnt_next   = '0;
                    state_next = S_START;
                end
            end
            S_START: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_HALF) begin
                    if (!rx_s_reg) begin
                        cnt_next   = '0;
                        idx_next   = '0;
                        state_next = S_DATA;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    shreg_next = {rx_s_reg, shreg_reg[7:1]};
                    cnt_next   = '0;
                    if (idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            S_STOP: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_s_reg ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s_reg) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        push_req = 1'b0;
        stop_bad = 1'b0;
        if (state_reg == S_STOP && cnt_reg == CNT_LAST) begin
            push_req = rx_s_reg;
            stop_bad = ~rx_s_reg;
        end
    end

    assign pop = data_valid & data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            framing_error_reg <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            framing_error_reg <= stop_bad;
            overrun_reg       <= push_req & fifo_full & ~pop;
        end
    end

    assign framing_error = framing_error_reg;
    assign overrun       = overrun_reg;
    assign data_valid    = ~fifo_empty;

    uart_rx_fifo #(
        .depth(fifo_depth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_req),
        .push_data(shreg_reg),
        .pop      (pop),
        .head     (data_out),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

endmodule
